// File: rtl/s_to_p_pkg.sv
// Shared types and defaults for the serial-to-parallel frame receiver.
package s_to_p_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam int   DATA_BITS_DEF  = 8;
  localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. It resets to the
// idle level so that coming out of reset does not look like a start bit.
module rx_sync
  import s_to_p_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_line,
  output logic sync_line
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= LINE_IDLE;
      sync_line <= LINE_IDLE;
    end else begin
      meta      <= async_line;
      sync_line <= meta;
    end
  end

endmodule

// File: rtl/s_to_p_rx.sv
// UART-style receiver: start bit, DATA_BITS data bits, stop bit, sampled at
// mid-bit from an oversampled line. Strobes each good byte and framing errors.
//
// state | meaning
// IDLE  | line idle, waiting for a tick with the line low
// START | counting to mid start bit to reject glitches
// DATA  | sampling data bits every OVERSAMPLE ticks
// STOP  | waiting for mid stop bit; high = good frame, low = framing error
// BREAK | line held low after a bad stop bit; wait for it to return high
module s_to_p_rx
  import s_to_p_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int MSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int BSC_W = $clog2(OVERSAMPLE);
  localparam int BIC_W = $clog2(DATA_BITS + 1);

  localparam logic [BSC_W-1:0] BSC_MID  = BSC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BSC_W-1:0] BSC_LAST = BSC_W'(OVERSAMPLE - 1);
  localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic [BSC_W-1:0]     bsc;
  logic [BIC_W-1:0]     bic;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 rx_s;
  logic                 bit_sample;
  logic                 stop_sample;
  logic                 good_stop;
  logic                 bad_stop;

  rx_sync u_rx_sync (
    .clk        (clk),
    .reset      (reset),
    .async_line (serial_in),
    .sync_line  (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sample_tick) begin
      case (state)
        IDLE:    if (!rx_s) state_nxt = START;
        START:   if (bsc == BSC_MID) state_nxt = rx_s ? IDLE : DATA;
        DATA:    if (bsc == BSC_LAST && bic == BIC_LAST) state_nxt = STOP;
        STOP:    if (bsc == BSC_LAST) state_nxt = rx_s ? IDLE : BREAK;
        BREAK:   if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    bit_sample  = sample_tick && (state == DATA) && (bsc == BSC_LAST);
    stop_sample = sample_tick && (state == STOP) && (bsc == BSC_LAST);
    good_stop   = stop_sample && rx_s;
    bad_stop    = stop_sample && !rx_s;
  end

  always_comb begin
    if (MSB_FIRST != 0) shift_nxt = {shift[DATA_BITS-2:0], rx_s};
    else                shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
  end

  // Counters and shift register only move on sample ticks; strobes are
  // registered so they appear the clk after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      bsc           <= '0;
      bic           <= '0;
      shift         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= good_stop;
      framing_error <= bad_stop;
      if (good_stop) data_out <= shift;
      if (bit_sample) begin
        shift <= shift_nxt;
        bic   <= bic + BIC_W'(1);
      end
      if (sample_tick) begin
        case (state)
          START: begin
            if (bsc == BSC_MID) begin
              bsc <= '0;
              bic <= '0;
            end else begin
              bsc <= bsc + BSC_W'(1);
            end
          end
          DATA, STOP: begin
            if (bsc == BSC_LAST) bsc <= '0;
            else                 bsc <= bsc + BSC_W'(1);
          end
          default: bsc <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s_to_p_rx.sv
// Scoreboard bench for s_to_p_rx: frames are pushed when driven and popped
// when data_valid fires.
module tb_s_to_p_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          serial_in = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          framing_error;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_div = 1;
  int tick_cnt = 0;
  int cyc = 0;
  int dv_count = 0;
  int fe_count = 0;
  int dv_cyc[$];
  logic [DB-1:0] sb[$];
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;

  always #5 clk = ~clk;

  s_to_p_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB), .MSB_FIRST(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    tick_cnt++;
    sample_tick = ((tick_cnt % tick_div) == 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_dv = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (data_valid) begin
        dv_count++;
        dv_cyc.push_back(cyc);
        chk("dv_width", prev_dv, 0);
        chk("dv_fe_excl", framing_error, 0);
        if (sb.size() == 0) chk("dv_unexpected", sb.size(), 1);
        else                chk("data_out", data_out, sb.pop_front());
      end
      if (framing_error) begin
        fe_count++;
        chk("fe_width", prev_fe, 0);
      end
      prev_dv = data_valid;
      prev_fe = framing_error;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    if (stop) sb.push_back(d);
    drive_bit(1'b0);
    for (int i = DB - 1; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal;
  end

  initial begin
    int dv0;
    int fe0;
    logic [DB-1:0] partial;

    wait_clks(3);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_framing_error", framing_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    wait_clks(5);

    // single frame, tick every clk
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'hA5, 1'b1);
    chk("a5_busy_after_stop", busy, 0);
    wait_clks(4);
    chk("a5_dv_count", dv_count - dv0, 1);
    chk("a5_fe_count", fe_count - fe0, 0);
    chk("a5_data_out", data_out, 8'hA5);
    chk("a5_sb_drain", sb.size(), 0);

    // back-to-back frames, no idle gap
    dv_cyc.delete();
    dv0 = dv_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(4);
    chk("b2b_dv_count", dv_count - dv0, 2);
    chk("b2b_strobes", dv_cyc.size(), 2);
    if (dv_cyc.size() == 2) chk("b2b_spacing", dv_cyc[1] - dv_cyc[0], 160);
    chk("b2b_data_out", data_out, 8'hFF);
    chk("b2b_sb_drain", sb.size(), 0);

    // short low glitch on idle line
    dv0 = dv_count; fe0 = fe_count;
    serial_in = 1'b0;
    wait_clks(4);
    serial_in = 1'b1;
    wait_clks(40);
    chk("glitch_dv", dv_count - dv0, 0);
    chk("glitch_fe", fe_count - fe0, 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_data_out", data_out, 8'hFF);

    // bad stop bit followed by a held-low break
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    serial_in = 1'b0;
    wait_clks(50);
    chk("brk_busy_low_line", busy, 1);
    chk("brk_fe_during", fe_count - fe0, 1);
    serial_in = 1'b1;
    wait_clks(5);
    chk("brk_busy_released", busy, 0);
    chk("brk_fe_total", fe_count - fe0, 1);
    chk("brk_dv", dv_count - dv0, 0);
    chk("brk_data_out", data_out, 8'hFF);

    // slow tick: one tick every 4 clks
    tick_div = 4;
    wait_clks(8);
    dv0 = dv_count;
    send_frame(8'h81, 1'b1);
    wait_clks(8);
    chk("slow_dv_count", dv_count - dv0, 1);
    chk("slow_data_out", data_out, 8'h81);
    chk("slow_sb_drain", sb.size(), 0);
    tick_div = 1;
    wait_clks(8);

    // reset during data bit 4, then a clean frame
    dv0 = dv_count; fe0 = fe_count;
    partial = 8'hC3;
    drive_bit(1'b0);
    for (int i = DB - 1; i > DB - 5; i--) drive_bit(partial[i]);
    serial_in = partial[DB-5];
    wait_clks(8);
    chk("mid_busy_before_rst", busy, 1);
    reset = 1'b1;
    wait_clks(1);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data_valid", data_valid, 0);
    chk("mid_rst_framing_error", framing_error, 0);
    reset = 1'b0;
    serial_in = 1'b1;
    wait_clks(40);
    chk("mid_rst_no_dv", dv_count - dv0, 0);
    chk("mid_rst_no_fe", fe_count - fe0, 0);
    send_frame(8'h5A, 1'b1);
    wait_clks(4);
    chk("post_rst_dv_count", dv_count - dv0, 1);
    chk("post_rst_data_out", data_out, 8'h5A);

    chk("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
